pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core. Merges the RAW-hazard stop,
//  data-bus wait, multi-cycle divider and branch/trap redirects into per-stage
//  enable and flush controls. Owns a 4-state FSM, a bus-wait watchdog, a trap-drain
//  counter and a stall-cycle counter. Sits beside the decode-stage hazard unit.
// PARAMETERS
//  MEM_TIMEOUT  256  max cycles in MEM_WAIT before forced release (>=2)
//  FLUSH_CYC    3    cycles spent in FLUSH after a trap (>=1)
//  CNT_W        32   width of stall_cnt
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  hz_stop      in   1      RAW-hazard stop from decode hazard unit
//  mem_req      in   1      MEM-stage load/store request to bus
//  mem_ack      in   1      bus acknowledge
//  div_start    in   1      EX-stage divide issued (1-cycle pulse)
//  div_done     in   1      divider result valid (1-cycle pulse)
//  br_taken     in   1      EX-stage branch/jump redirect
//  trap_req     in   1      trap/interrupt request, level, held until trap_ack
//  trap_ack     out  1      1-cycle pulse on RUN->FLUSH
//  pc_en        out  1      PC update enable
//  if_id_en     out  1      IF/ID register enable
//  id_ex_en     out  1      ID/EX register enable
//  ex_mem_en    out  1      EX/MEM register enable
//  mem_wb_en    out  1      MEM/WB register enable
//  if_id_flush  out  1      load bubble into IF/ID
//  id_ex_flush  out  1      load bubble into ID/EX
//  mem_timeout  out  1      1-cycle pulse on watchdog expiry
//  state        out  2      RUN=0 MEM_WAIT=1 DIV_WAIT=2 FLUSH=3
//  stall_cnt    out  CNT_W  cycles with pc_en=0, saturating
// BEHAVIOUR
//  - Controls are combinational from state/counters/inputs. While rst=1: all *_en=0,
//    both flushes=1, trap_ack=mem_timeout=0. On the reset edge: state=RUN, timers=0,
//    stall_cnt=0.
//  - Default (no event): all enables 1, flushes 0.
//  - RUN priority, highest first:
//    1. mem_req&!mem_ack: all enables 0; next MEM_WAIT, wdog=0.
//    2. trap_req: trap_ack=1, both flushes=1, pc_en=0; next FLUSH, fcnt=FLUSH_CYC-1.
//    3. div_start: pc/if_id/id_ex/ex_mem_en=0, mem_wb_en=1; next DIV_WAIT.
//    4. br_taken: if_id_flush=id_ex_flush=1, all enables 1; stay RUN.
//       Overrides hz_stop.
//    5. hz_stop: pc_en=if_id_en=0, id_ex_flush=1, rest enabled; stay RUN.
//  - MEM_WAIT: all enables 0 until release.
//    - mem_ack: all enables 1; next RUN.
//    - else if wdog==MEM_TIMEOUT-1: mem_timeout=1, all enables 1; next RUN.
//    - else wdog+1.
//    - Max residency: MEM_TIMEOUT cycles. trap_req/br_taken/hz_stop are ignored here.
//  - DIV_WAIT: same enables as RUN case 3. On div_done: all enables 1; next RUN.
//    No timeout. trap_req waits until back in RUN.
//  - FLUSH: both flushes=1, if_id/id_ex/ex_mem/mem_wb_en=1.
//    - pc_en=0 while fcnt!=0, and fcnt decrements.
//    - At fcnt==0: pc_en=1 (loads trap vector); next RUN.
//    - Total FLUSH residency: FLUSH_CYC cycles. Inputs other than rst are ignored.
//  - stall_cnt: +1 on every non-reset cycle with pc_en=0; holds at 2^CNT_W-1.
//  - rst mid-operation in any state: the next state is RUN and all counters clear.
//    Any in-flight trap_req must be re-presented.
//  - wdog width: $clog2(MEM_TIMEOUT)+1.
// TESTING
//  1. hz_stop=1 for 2 cycles in RUN -> pc_en=if_id_en=0 and id_ex_flush=1 for 2 cycles;
//     state stays 0; stall_cnt=2.
//  2. mem_req=1, mem_ack arrives 4 cycles later -> all enables 0 for 4 cycles,
//     all 1 in the ack cycle; state 1->0; stall_cnt=4.
//  3. MEM_TIMEOUT=8, mem_req=1, no ack -> mem_timeout pulses in the 8th MEM_WAIT
//     cycle; state returns to 0 next cycle.
//  4. trap_req with FLUSH_CYC=3 -> trap_ack for 1 cycle, then 3 FLUSH cycles
//     with pc_en=0,0,1; br_taken during FLUSH has no effect.
//  5. div_start, div_done 5 cycles later, br_taken+hz_stop in the same cycle
//     during the wait -> ex_mem_en=0, mem_wb_en=1 throughout; after return,
//     br_taken+hz_stop together -> both flushes, pc_en=1.
//  6. rst pulsed in MEM_WAIT and in FLUSH -> outputs take their reset values,
//     next state=0, stall_cnt=0, trap_ack is not repeated.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between the pipeline sequencer and the 5-stage core.
// master = sequencer (consumes hazard/bus/divider/redirect events, drives stage controls).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             hz_stop;
  logic             mem_req;
  logic             mem_ack;
  logic             div_start;
  logic             div_done;
  logic             br_taken;
  logic             trap_req;
  logic             trap_ack;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  hz_stop, mem_req, mem_ack, div_start, div_done, br_taken, trap_req,
    output trap_ack, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_timeout, state, stall_cnt
  );

  modport slave (
    output hz_stop, mem_req, mem_ack, div_start, div_done, br_taken, trap_req,
    input  trap_ack, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_timeout, state, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: merges hazard, bus-wait, divider and redirect events.
// Controls are combinational from state/counters/inputs (0-cycle); bus wait bounded by a watchdog.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int FLUSH_CYC   = 3,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master bus
);
  localparam int WD_W = $clog2(MEM_TIMEOUT) + 1;
  localparam int FC_W = $clog2(FLUSH_CYC) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, trap_ack, mem_timeout;

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    fcnt_d      = fcnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    trap_ack    = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          state_d = MEM_WAIT;
          wdog_d  = '0;
        end else if (bus.trap_req) begin
          trap_ack    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          pc_en       = 1'b0;
          state_d     = FLUSH;
          fcnt_d      = FC_W'(FLUSH_CYC - 1);
        end else if (bus.div_start) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0;
          state_d = DIV_WAIT;
        end else if (bus.br_taken) begin
          // Redirect squashes the younger instructions, so a pending hazard stop is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.hz_stop) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_d = RUN;
        end else if (wdog_q == WD_W'(MEM_TIMEOUT - 1)) begin
          mem_timeout = 1'b1;
          state_d     = RUN;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      DIV_WAIT: begin
        if (bus.div_done) begin
          state_d = RUN;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        // Last flush cycle releases the PC so it loads the trap vector.
        if (fcnt_q != '0) begin
          pc_en  = 1'b0;
          fcnt_d = fcnt_q - FC_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      trap_ack    = 1'b0;
      mem_timeout = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wdog_q      <= '0;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.trap_ack    = trap_ack;
  assign bus.mem_timeout = mem_timeout;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: cycle-stamp reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_pipe_ctrl;
  localparam int     MEM_TIMEOUT = 8;
  localparam int     FLUSH_CYC   = 3;
  localparam int     CNT_W       = 6;
  localparam longint STALL_MAX   = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipe_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .FLUSH_CYC  (FLUSH_CYC),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, ack, tmo;
  } exp_t;

  int     n_vec = 0;
  int     n_bad = 0;
  bit     chk_on = 1'b0;
  bit     last_ack = 1'b0;
  int     m_mode = 0;        // 0 run, 1 bus wait, 2 divide wait, 3 flush
  longint m_cyc = 0;         // absolute cycle index
  longint m_mem_last = 0;    // last cycle the bus wait may occupy
  longint m_flush_end = 0;   // cycle in which the flush releases the PC
  longint m_stall = 0;

  function automatic exp_t model_out();
    exp_t e;
    e = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1,
          fl_ifid: 1'b0, fl_idex: 1'b0, ack: 1'b0, tmo: 1'b0};
    if (rst) begin
      e = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0,
            fl_ifid: 1'b1, fl_idex: 1'b1, ack: 1'b0, tmo: 1'b0};
      return e;
    end
    case (m_mode)
      0: begin
        if (bus.mem_req && !bus.mem_ack) begin
          e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
        end else if (bus.trap_req) begin
          e.ack = 1; e.fl_ifid = 1; e.fl_idex = 1; e.pc = 0;
        end else if (bus.div_start) begin
          e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0;
        end else if (bus.br_taken) begin
          e.fl_ifid = 1; e.fl_idex = 1;
        end else if (bus.hz_stop) begin
          e.pc = 0; e.ifid = 0; e.fl_idex = 1;
        end
      end
      1: begin
        if (!bus.mem_ack && m_cyc == m_mem_last) e.tmo = 1;
        else if (!bus.mem_ack) begin
          e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
        end
      end
      2: if (!bus.div_done) begin
        e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0;
      end
      default: begin
        e.fl_ifid = 1; e.fl_idex = 1;
        e.pc = (m_cyc == m_flush_end);
      end
    endcase
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    if (rst) begin
      m_mode  = 0;
      m_stall = 0;
    end else begin
      if (!e.pc && m_stall < STALL_MAX) m_stall++;
      case (m_mode)
        0: begin
          if (bus.mem_req && !bus.mem_ack) begin
            m_mode = 1; m_mem_last = m_cyc + MEM_TIMEOUT;
          end else if (bus.trap_req) begin
            m_mode = 3; m_flush_end = m_cyc + FLUSH_CYC;
          end else if (bus.div_start) begin
            m_mode = 2;
          end
        end
        1: if (bus.mem_ack || e.tmo) m_mode = 0;
        2: if (bus.div_done) m_mode = 0;
        default: if (e.pc) m_mode = 0;
      endcase
    end
    m_cyc++;
  endtask

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      e = model_out();
      cmp("pc_en",       64'(bus.pc_en),       64'(e.pc));
      cmp("if_id_en",    64'(bus.if_id_en),    64'(e.ifid));
      cmp("id_ex_en",    64'(bus.id_ex_en),    64'(e.idex));
      cmp("ex_mem_en",   64'(bus.ex_mem_en),   64'(e.exmem));
      cmp("mem_wb_en",   64'(bus.mem_wb_en),   64'(e.memwb));
      cmp("if_id_flush", 64'(bus.if_id_flush), 64'(e.fl_ifid));
      cmp("id_ex_flush", 64'(bus.id_ex_flush), 64'(e.fl_idex));
      cmp("trap_ack",    64'(bus.trap_ack),    64'(e.ack));
      cmp("mem_timeout", 64'(bus.mem_timeout), 64'(e.tmo));
      cmp("state",       64'(bus.state),       64'(m_mode));
      cmp("stall_cnt",   64'(bus.stall_cnt),   64'(m_stall));
    end
  end

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    e = model_out();
    last_ack = e.ack;
    model_step(e);
    chk_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    bus.hz_stop = 0; bus.mem_req = 0; bus.mem_ack = 0; bus.div_start = 0;
    bus.div_done = 0; bus.br_taken = 0; bus.trap_req = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  bit trap_pend;

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    #1;
    cmp("rst_pc_en", 64'(bus.pc_en), 64'd0);
    cmp("rst_flush", 64'({bus.if_id_flush, bus.id_ex_flush}), 64'd3);
    cmp("rst_state", 64'(bus.state), 64'd0);
    cmp("rst_stall", 64'(bus.stall_cnt), 64'd0);
    cyc();
    rst = 1'b0;

    // Hazard stop for two cycles
    bus.hz_stop = 1; #1;
    cmp("t1_pc_en", 64'(bus.pc_en), 64'd0);
    cmp("t1_flush", 64'(bus.id_ex_flush), 64'd1);
    cyc(); #1;
    cmp("t1_ifid_en", 64'(bus.if_id_en), 64'd0);
    cyc();
    bus.hz_stop = 0; #1;
    cmp("t1_state", 64'(bus.state), 64'd0);
    cmp("t1_stall", 64'(bus.stall_cnt), 64'd2);

    // Bus wait acknowledged four cycles after the request
    do_reset();
    bus.mem_req = 1; #1;
    cmp("t2_en0", 64'({bus.pc_en, bus.mem_wb_en}), 64'd0);
    cyc(); #1;
    cmp("t2_state", 64'(bus.state), 64'd1);
    cyc(); cyc(); cyc();
    bus.mem_ack = 1; #1;
    cmp("t2_ack_en", 64'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}), 64'd31);
    cyc();
    idle(); #1;
    cmp("t2_state_back", 64'(bus.state), 64'd0);
    cmp("t2_stall", 64'(bus.stall_cnt), 64'd4);

    // Watchdog expiry
    do_reset();
    bus.mem_req = 1;
    cyc();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      #1;
      cmp("t3_tmo", 64'(bus.mem_timeout), 64'(i == MEM_TIMEOUT));
      cyc();
    end
    bus.mem_req = 0; #1;
    cmp("t3_state", 64'(bus.state), 64'd0);
    cmp("t3_stall", 64'(bus.stall_cnt), 64'(MEM_TIMEOUT));

    // Trap and flush, branch ignored during flush
    do_reset();
    bus.trap_req = 1; #1;
    cmp("t4_ack", 64'(bus.trap_ack), 64'd1);
    cyc();
    bus.trap_req = 0; bus.br_taken = 1;
    for (int i = 0; i < FLUSH_CYC; i++) begin
      #1;
      cmp("t4_pc_en", 64'(bus.pc_en), 64'(i == FLUSH_CYC - 1));
      cmp("t4_state", 64'(bus.state), 64'd3);
      cyc();
    end
    bus.br_taken = 0; #1;
    cmp("t4_state_back", 64'(bus.state), 64'd0);

    // Divide wait with branch+hazard during the wait and after return
    do_reset();
    bus.div_start = 1; #1;
    cmp("t5_exmem", 64'({bus.ex_mem_en, bus.mem_wb_en}), 64'd1);
    cyc();
    bus.div_start = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.br_taken = (i == 2); bus.hz_stop = (i == 2); bus.div_done = (i == 5); #1;
      if (i < 5) cmp("t5_wait_en", 64'({bus.ex_mem_en, bus.mem_wb_en, bus.if_id_flush}), 64'd2);
      else cmp("t5_done_en", 64'(bus.pc_en), 64'd1);
      cyc();
    end
    idle(); bus.br_taken = 1; bus.hz_stop = 1; #1;
    cmp("t5_br_hz", 64'({bus.if_id_flush, bus.id_ex_flush, bus.pc_en}), 64'd7);
    cyc();

    // Reset mid bus wait and mid flush
    do_reset();
    bus.mem_req = 1;
    cyc();
    idle(); rst = 1; #1;
    cmp("t6_mw_pc", 64'(bus.pc_en), 64'd0);
    cmp("t6_mw_state", 64'(bus.state), 64'd1);
    cyc();
    rst = 0; #1;
    cmp("t6_mw_back", 64'({bus.state, bus.stall_cnt}), 64'd0);
    bus.trap_req = 1;
    cyc();
    bus.trap_req = 0; rst = 1; #1;
    cmp("t6_fl_ack", 64'(bus.trap_ack), 64'd0);
    cyc();
    rst = 0; #1;
    cmp("t6_fl_state", 64'(bus.state), 64'd0);
    cmp("t6_fl_ack2", 64'(bus.trap_ack), 64'd0);
    cmp("t6_fl_stall", 64'(bus.stall_cnt), 64'd0);

    // Randomized traffic
    trap_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst           = ($urandom_range(0, 149) == 0);
      bus.mem_req   = ($urandom_range(0, 3) == 0);
      bus.mem_ack   = ($urandom_range(0, 2) == 0);
      bus.div_start = ($urandom_range(0, 7) == 0);
      bus.div_done  = ($urandom_range(0, 5) == 0);
      bus.br_taken  = ($urandom_range(0, 4) == 0);
      bus.hz_stop   = ($urandom_range(0, 3) == 0);
      if (last_ack) trap_pend = 0;
      if (!trap_pend && $urandom_range(0, 29) == 0) trap_pend = 1;
      bus.trap_req  = trap_pend;
    end
    cyc();
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
